road_sequencer: RTL and testbench
=================================

// Module: road_sequencer
// PURPOSE
//  Game/road scheduler: sequences the curvature script, difficulty level and crash/respawn flow for the
//  scrolling-road renderer. Once per scan-line tick it issues the next road-centre column (new row 0);
//  the renderer shifts its edge memories and draws. Sits between VGA timing/collision logic and the road datapath.
// PARAMETERS
//  SCRIPT_LEN   4    script entries (fixed table: {0,10},{+6,18},{0,10},{-6,18} = {delta,rows})
//  XCENTER      464  road centre after reset/respawn
//  ROAD_HALF    50   half road width in pixels
//  SCREEN_MAX   639  rightmost legal edge column (leftmost is 0)
//  LEVEL_ROWS   56   row ticks per level step
//  MAX_LEVEL    8    level ceiling
//  CRASH_ROWS   120  row ticks frozen in CRASH before respawn
// PORTS
//  clk         in   1   pixel clock
//  rst_n       in   1   synchronous reset, active low
//  row_tick    in   1   one-cycle pulse per scan line (hCount==0)
//  crash       in   1   collision detected (level sensitive)
//  start       in   1   player start/steer button (any press)
//  row_valid   out  1   one-cycle pulse: center_x/left_x/right_x hold new row-0 values
//  center_x    out  10  road centre column
//  left_x      out  10  center_x - ROAD_HALF
//  right_x     out  10  center_x + ROAD_HALF
//  level       out  4   difficulty 1..MAX_LEVEL
//  state       out  2   00 IDLE, 01 PLAY, 10 CRASH, 11 RESPAWN
//  clear_road  out  1   one-cycle pulse: renderer reloads all rows to straight road
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, center_x=XCENTER, left/right derived, level=1, row_valid=0,
//   clear_road=0, script ptr=0, rows_left=0, distance=0. Reset mid-game aborts immediately, no clear pulse.
//  IDLE: no row_valid. start=1 -> PLAY next cycle.
//  PLAY, on row_tick: registered, row_valid asserted exactly 1 cycle after row_tick.
//   - rows_left==0: load entry[ptr]; delta=base+level if base>0, base-level if base<0, 0 if base==0;
//     delta signed 6b, saturate to +/-31; rows_left=rows[ptr]; ptr wraps SCRIPT_LEN-1 -> 0.
//   - else rows_left-1; delta held.
//   - new=center_x+delta (signed 11b); commit only if new-ROAD_HALF>=0 and new+ROAD_HALF<=SCREEN_MAX,
//     else center_x unchanged (row_valid still pulses with old values).
//   - distance+1; at distance==LEVEL_ROWS-1 wrap to 0 and level+1 unless level==MAX_LEVEL.
//  crash=1 in PLAY -> CRASH next cycle; crash takes priority over same-cycle row_tick (no update that tick).
//  CRASH: counts CRASH_ROWS row_ticks, no row_valid, crash/start ignored; then RESPAWN.
//  RESPAWN (one cycle): clear_road=1, center_x=XCENTER, level=1, ptr/rows_left/distance=0; -> IDLE.
//  row_tick outside PLAY/CRASH ignored. Unknown state encoding -> IDLE.
// CONFIGURATION
//  HIGH_SCORE_EN defined: extra port best_rows out 16: total PLAY row_ticks of current run tracked
//   (saturating 0xFFFF); on entry to RESPAWN best_rows=max(best_rows,run); cleared only by rst_n.
//  Undefined: port absent, no run/best counters; all other behaviour identical.
// TESTING
//  rst_n low 2 clk, release -> state=0, center_x=464, left_x=414, right_x=514, level=1, no row_valid.
//  start, 11 row_ticks -> rows 1-11 delta 0; tick 12 loads +6+1 -> center_x=471, row_valid 1 clk after.
//  Hold PLAY 56 row_ticks -> level=2; 500 ticks -> level saturates at 8.
//  Force center near edge (run only right bends) -> center_x never exceeds 589, right_x<=639.
//  crash on same cycle as row_tick -> no row_valid; state=CRASH; 120 ticks -> clear_road 1 clk, center_x=464, IDLE.
//  HIGH_SCORE_EN: run 300 ticks crash, then 100 ticks crash -> best_rows=300 after both respawns.

Source files
------------

// File: rtl/road_sequencer.sv
// road_sequencer: curvature-script / difficulty / crash-respawn scheduler for
// the scrolling-road renderer. Issues one new row-0 road centre per row_tick
// while in PLAY, freezes for a fixed number of rows after a crash, then
// respawns with a one-cycle clear_road pulse.
// Optional feature macro: HIGH_SCORE_EN adds best_rows (longest run in rows).
module road_sequencer #(
   parameter int SCRIPT_LEN = 4,
   parameter int XCENTER    = 464,
   parameter int ROAD_HALF  = 50,
   parameter int SCREEN_MAX = 639,
   parameter int LEVEL_ROWS = 56,
   parameter int MAX_LEVEL  = 8,
   parameter int CRASH_ROWS = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        row_tick,
   input  logic        crash,
   input  logic        start,
   output logic        row_valid,
   output logic [9:0]  center_x,
   output logic [9:0]  left_x,
   output logic [9:0]  right_x,
   output logic [3:0]  level,
   output logic [1:0]  state,
   output logic        clear_road
`ifdef HIGH_SCORE_EN
   ,
   output logic [15:0] best_rows
`endif
);

   localparam int PW = (SCRIPT_LEN > 1) ? $clog2(SCRIPT_LEN) : 1;
   localparam int DW = (LEVEL_ROWS > 1) ? $clog2(LEVEL_ROWS) : 1;
   localparam int CW = (CRASH_ROWS > 1) ? $clog2(CRASH_ROWS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_PLAY    = 2'b01,
      S_CRASH   = 2'b10,
      S_RESPAWN = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic                do_row, crash_done;
   logic [PW-1:0]       ptr_q;
   logic [4:0]          rows_left_q;
   logic signed [5:0]   delta_q;
   logic [DW-1:0]       dist_q;
   logic [CW-1:0]       crash_cnt_q;
   logic [9:0]          center_q;
   logic [3:0]          level_q;

   // script entry lookup, delta scaling and edge-limit check
   logic signed [5:0]   base;
   logic [4:0]          entry_rows;
   logic signed [7:0]   raw;
   logic signed [5:0]   delta_new, delta_use;
   logic [10:0]         sum;
   logic                fits;

   // fixed curvature table {delta, rows}
   always_comb begin
      base       = 6'sd0;
      entry_rows = 5'd10;
      case (ptr_q)
         PW'(0): begin base = 6'sd0;  entry_rows = 5'd10; end
         PW'(1): begin base = 6'sd6;  entry_rows = 5'd18; end
         PW'(2): begin base = 6'sd0;  entry_rows = 5'd10; end
         PW'(3): begin base = -6'sd6; entry_rows = 5'd18; end
         default: begin base = 6'sd0; entry_rows = 5'd10; end
      endcase
   end

   // bend strength grows with level in the bend's own direction, capped at +/-31
   always_comb begin
      raw = 8'sd0;
      if (base[5])
         raw = {{2{base[5]}}, base} - $signed({4'b0, level_q});
      else if (base != 6'sd0)
         raw = {{2{base[5]}}, base} + $signed({4'b0, level_q});
      if (raw > 8'sd31)
         delta_new = 6'sd31;
      else if (raw < -8'sd31)
         delta_new = -6'sd31;
      else
         delta_new = raw[5:0];
      delta_use = (rows_left_q == 5'd0) ? delta_new : delta_q;
      // negative results wrap to large unsigned values and fail the upper bound
      sum  = {1'b0, center_q} + {{5{delta_use[5]}}, delta_use};
      fits = (sum >= 11'(ROAD_HALF)) && (sum <= 11'(SCREEN_MAX - ROAD_HALF));
   end

   // next-state and per-cycle strobes; crash beats a same-cycle row_tick
   always_comb begin
      state_d    = state_q;
      do_row     = 1'b0;
      crash_done = 1'b0;
      case (state_q)
         S_IDLE:    if (start) state_d = S_PLAY;
         S_PLAY: begin
            if (crash)         state_d = S_CRASH;
            else if (row_tick) do_row  = 1'b1;
         end
         S_CRASH: begin
            if (row_tick && crash_cnt_q == CW'(CRASH_ROWS - 1)) begin
               crash_done = 1'b1;
               state_d    = S_RESPAWN;
            end
         end
         S_RESPAWN: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // state, road position, script progress and level registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         row_valid   <= 1'b0;
         center_q    <= 10'(XCENTER);
         level_q     <= 4'd1;
         ptr_q       <= '0;
         rows_left_q <= '0;
         delta_q     <= '0;
         dist_q      <= '0;
         crash_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         row_valid <= do_row;
         if (do_row) begin
            if (rows_left_q == 5'd0) begin
               delta_q     <= delta_new;
               rows_left_q <= entry_rows;
               ptr_q       <= (ptr_q == PW'(SCRIPT_LEN - 1)) ? '0 : ptr_q + 1'b1;
            end else begin
               rows_left_q <= rows_left_q - 5'd1;
            end
            if (fits) center_q <= sum[9:0];
            if (dist_q == DW'(LEVEL_ROWS - 1)) begin
               dist_q <= '0;
               if (level_q != 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
            end else begin
               dist_q <= dist_q + 1'b1;
            end
         end
         if (state_q == S_PLAY && crash)
            crash_cnt_q <= '0;
         else if (state_q == S_CRASH && row_tick)
            crash_cnt_q <= crash_done ? '0 : crash_cnt_q + 1'b1;
         // respawn values are visible during the clear_road cycle
         if (crash_done) begin
            center_q    <= 10'(XCENTER);
            level_q     <= 4'd1;
            ptr_q       <= '0;
            rows_left_q <= '0;
            delta_q     <= '0;
            dist_q      <= '0;
         end
      end
   end

`ifdef HIGH_SCORE_EN
   logic [15:0] run_q;

   // run length in PLAY rows; folded into best on entry to RESPAWN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q     <= '0;
         best_rows <= '0;
      end else if (crash_done) begin
         run_q <= '0;
         if (run_q > best_rows) best_rows <= run_q;
      end else if (do_row && run_q != 16'hFFFF) begin
         run_q <= run_q + 16'd1;
      end
   end
`endif

   assign center_x   = center_q;
   assign left_x     = center_q - 10'(ROAD_HALF);
   assign right_x    = center_q + 10'(ROAD_HALF);
   assign level      = level_q;
   assign state      = state_q;
   assign clear_road = (state_q == S_RESPAWN);

endmodule

// File: tb/tb_road_sequencer.sv
// Scoreboard bench for road_sequencer: a behavioural road model pushes the
// expected row-0 values for every row_tick; a negedge monitor pops them when
// row_valid fires.
module tb_road_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       row_tick = 1'b0;
   logic       crash = 1'b0;
   logic       start = 1'b0;
   logic       row_valid;
   logic [9:0] center_x, left_x, right_x;
   logic [3:0] level;
   logic [1:0] state;
   logic       clear_road;
`ifdef HIGH_SCORE_EN
   logic [15:0] best_rows;
`endif

   road_sequencer dut (
      .clk(clk), .rst_n(rst_n), .row_tick(row_tick), .crash(crash), .start(start),
      .row_valid(row_valid), .center_x(center_x), .left_x(left_x), .right_x(right_x),
      .level(level), .state(state), .clear_road(clear_road)
`ifdef HIGH_SCORE_EN
      , .best_rows(best_rows)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int c; int l; } exp_t;
   exp_t q[$];

   int total = 0;
   int bad   = 0;
   int max_center = 0;
   int max_right  = 0;

   // model state
   int sb[4] = '{0, 6, 0, -6};
   int sr[4] = '{10, 18, 10, 18};
   int m_center, m_level, m_ptr, m_rows, m_delta, m_dist, m_run, m_best;

   function automatic void model_reset(input bit full);
      m_center = 464; m_level = 1; m_ptr = 0; m_rows = 0;
      m_delta = 0; m_dist = 0; m_run = 0;
      if (full) m_best = 0;
   endfunction

   function automatic void model_tick();
      int d, nc;
      exp_t e;
      if (m_rows == 0) begin
         if (sb[m_ptr] > 0)      d = sb[m_ptr] + m_level;
         else if (sb[m_ptr] < 0) d = sb[m_ptr] - m_level;
         else                    d = 0;
         if (d > 31)  d = 31;
         if (d < -31) d = -31;
         m_delta = d;
         m_rows  = sr[m_ptr];
         m_ptr   = (m_ptr + 1) % 4;
      end else begin
         m_rows = m_rows - 1;
      end
      nc = m_center + m_delta;
      if (nc - 50 >= 0 && nc + 50 <= 639) m_center = nc;
      if (m_dist == 55) begin
         m_dist = 0;
         if (m_level < 8) m_level = m_level + 1;
      end else begin
         m_dist = m_dist + 1;
      end
      if (m_run < 65535) m_run = m_run + 1;
      e.c = m_center; e.l = m_level;
      q.push_back(e);
   endfunction

   function automatic void model_respawn();
      if (m_run > m_best) m_best = m_run;
      model_reset(1'b0);
   endfunction

   // scoreboard consumer
   always @(negedge clk) begin
      if (rst_n && row_valid) begin
         exp_t e;
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_row_valid: got row_valid=1 center=%0d, none expected", center_x);
         end else begin
            e = q.pop_front();
            if (center_x !== 10'(e.c) || left_x !== 10'(e.c - 50) ||
                right_x !== 10'(e.c + 50) || level !== 4'(e.l)) begin
               bad++;
               $display("FAIL row_values: got c=%0d l=%0d r=%0d lvl=%0d, want c=%0d l=%0d r=%0d lvl=%0d",
                        center_x, left_x, right_x, level, e.c, e.c - 50, e.c + 50, e.l);
            end
         end
         if (int'(center_x) > max_center) max_center = int'(center_x);
         if (int'(right_x) > max_right)   max_right  = int'(right_x);
      end
   end

   task automatic tick_once();
      row_tick = 1'b1;
      model_tick();
      @(posedge clk); #1;
      row_tick = 1'b0;
      total++;
      if (row_valid !== 1'b1) begin
         bad++;
         $display("FAIL row_valid_latency: got %b want 1", row_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic crash_tick();
      row_tick = 1'b1;
      @(posedge clk); #1;
      row_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic press_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (state !== 2'b01) begin
         bad++;
         $display("FAIL start_to_play: got state=%0d want 1", state);
      end
   endtask

   // crash (optionally coinciding with a row_tick), 120 frozen rows, respawn
   task automatic crash_and_respawn(input bit with_tick);
      crash = 1'b1;
      row_tick = with_tick;
      @(posedge clk); #1;
      crash = 1'b0;
      row_tick = 1'b0;
      total++;
      if (row_valid !== 1'b0 || state !== 2'b10) begin
         bad++;
         $display("FAIL crash_entry: got row_valid=%b state=%0d want 0/2", row_valid, state);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 119; i++) crash_tick();
      total++;
      if (state !== 2'b10 || clear_road !== 1'b0) begin
         bad++;
         $display("FAIL crash_hold: got state=%0d clear=%b want 2/0", state, clear_road);
      end
      row_tick = 1'b1;
      @(posedge clk); #1;
      row_tick = 1'b0;
      model_respawn();
      total++;
      if (state !== 2'b11 || clear_road !== 1'b1 || center_x !== 10'd464 || level !== 4'd1) begin
         bad++;
         $display("FAIL respawn: got state=%0d clear=%b c=%0d lvl=%0d want 3/1/464/1",
                  state, clear_road, center_x, level);
      end
      @(posedge clk); #1;
      total++;
      if (state !== 2'b00 || clear_road !== 1'b0) begin
         bad++;
         $display("FAIL respawn_to_idle: got state=%0d clear=%b want 0/0", state, clear_road);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      q.delete();
      model_reset(1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      total++;
      if (state !== 2'b00 || center_x !== 10'd464 || left_x !== 10'd414 || right_x !== 10'd514 ||
          level !== 4'd1 || row_valid !== 1'b0 || clear_road !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got st=%0d c=%0d l=%0d r=%0d lvl=%0d rv=%b clr=%b",
                  state, center_x, left_x, right_x, level, row_valid, clear_road);
      end
      // tick in IDLE must be ignored (monitor flags any row_valid)
      crash_tick();
      total++;
      if (state !== 2'b00 || center_x !== 10'd464) begin
         bad++;
         $display("FAIL idle_tick: got state=%0d c=%0d want 0/464", state, center_x);
      end
   endtask

   task automatic test_script();
      press_start();
      for (int i = 0; i < 11; i++) tick_once();
      total++;
      if (center_x !== 10'd464) begin
         bad++;
         $display("FAIL straight_rows: got c=%0d want 464", center_x);
      end
      tick_once();
      total++;
      if (center_x !== 10'd471) begin
         bad++;
         $display("FAIL first_bend: got c=%0d want 471", center_x);
      end
   endtask

   task automatic test_level();
      for (int i = 12; i < 56; i++) tick_once();
      total++;
      if (level !== 4'd2) begin
         bad++;
         $display("FAIL level_step: got %0d want 2", level);
      end
      for (int i = 56; i < 500; i++) tick_once();
      total++;
      if (level !== 4'd8) begin
         bad++;
         $display("FAIL level_sat: got %0d want 8", level);
      end
      total++;
      if (max_center > 589 || max_right > 639) begin
         bad++;
         $display("FAIL edge_limit: got max_c=%0d max_r=%0d want <=589/<=639", max_center, max_right);
      end
      total++;
      if (center_x !== 10'(m_center)) begin
         bad++;
         $display("FAIL center_track: got %0d want %0d", center_x, m_center);
      end
   endtask

   task automatic test_crash();
      crash_and_respawn(1'b1);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_rows: got %0d outstanding want 0", q.size());
      end
   endtask

   task automatic test_back_to_back();
      press_start();
      row_tick = 1'b1;
      for (int i = 0; i < 30; i++) begin
         model_tick();
         @(posedge clk); #1;
         total++;
         if (row_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_valid: got %b want 1 at tick %0d", row_valid, i);
         end
      end
      row_tick = 1'b0;
      @(posedge clk); #1;
      total++;
      if (q.size() != 0 || row_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: got %0d outstanding rv=%b want 0/0", q.size(), row_valid);
      end
   endtask

`ifdef HIGH_SCORE_EN
   task automatic test_high_score();
      test_reset();
      press_start();
      for (int i = 0; i < 300; i++) tick_once();
      crash_and_respawn(1'b0);
      total++;
      if (best_rows !== 16'(m_best) || m_best != 300) begin
         bad++;
         $display("FAIL best_first: got %0d want 300", best_rows);
      end
      press_start();
      for (int i = 0; i < 100; i++) tick_once();
      crash_and_respawn(1'b0);
      total++;
      if (best_rows !== 16'd300) begin
         bad++;
         $display("FAIL best_second: got %0d want 300", best_rows);
      end
   endtask
`endif

   task automatic test_reset_mid_game();
      press_start();
      for (int i = 0; i < 5; i++) tick_once();
      crash = 1'b1;
      @(posedge clk); #1;
      crash = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset(1'b1);
      total++;
      if (state !== 2'b00 || clear_road !== 1'b0 || center_x !== 10'd464) begin
         bad++;
         $display("FAIL mid_reset: got st=%0d clr=%b c=%0d want 0/0/464", state, clear_road, center_x);
      end
   endtask

   initial begin
      model_reset(1'b1);
      @(posedge clk); #1;
      test_reset();
      test_script();
      test_level();
      test_crash();
      test_back_to_back();
      test_reset_mid_game();
`ifdef HIGH_SCORE_EN
      test_high_score();
`endif
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
